// File: rtl/dpwm_sequencer_if.sv
// Control/status bundle between a DPWM supervisor and dpwm_sequencer.
// master drives requests and targets; slave (the sequencer) returns the DPWM commands.
interface dpwm_sequencer_if;
  logic       start;
  logic       stop;
  logic       fault;
  logic       fault_clr;
  logic       period_end;
  logic [9:0] duty_target;
  logic [9:0] maxcount_target;
  logic [7:0] ramp_div;
  logic       en;
  logic [9:0] duty_cmd;
  logic [9:0] maxcount_cmd;
  logic [2:0] state;
  logic       fault_latched;

  modport master (
    output start, stop, fault, fault_clr, period_end,
           duty_target, maxcount_target, ramp_div,
    input  en, duty_cmd, maxcount_cmd, state, fault_latched
  );

  modport slave (
    input  start, stop, fault, fault_clr, period_end,
           duty_target, maxcount_target, ramp_div,
    output en, duty_cmd, maxcount_cmd, state, fault_latched
  );
endinterface

// File: rtl/dpwm_sequencer.sv
// Soft-start / shutdown / fault sequencer producing registered DPWM enable, duty and period.
// Optional macro DPWM_SEQ_RAMPDOWN_EN adds a ramp-down state on stop; otherwise stop cuts off at once.
module dpwm_sequencer #(
  parameter int STEP = 1,
  parameter int DMIN = 0
) (
  input logic           clk,
  input logic           reset,
  dpwm_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RAMP   = 3'd1,
    S_RUN    = 3'd2,
`ifdef DPWM_SEQ_RAMPDOWN_EN
    S_RAMPDN = 3'd3,
`endif
    S_FAULT  = 3'd4
  } state_t;

  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [9:0]  DMIN_W = 10'(DMIN);

  state_t     state_q, state_d;
  logic       en_q, en_d;
  logic       fl_q, fl_d;
  logic [9:0] duty_q, duty_d;
  logic [9:0] max_q, max_d;
  logic [7:0] tick_q, tick_d;

  function automatic logic [9:0] min10(input logic [9:0] a, input logic [9:0] b);
    return (a < b) ? a : b;
  endfunction

  // 11-bit sum so a large duty plus STEP saturates at the limit instead of wrapping
  function automatic logic [9:0] sat_up(input logic [9:0] d, input logic [9:0] lim);
    logic [10:0] s;
    s = {1'b0, d} + STEP_W;
    return (s > {1'b0, lim}) ? lim : s[9:0];
  endfunction

  function automatic logic [9:0] sat_dn(input logic [9:0] d);
    return ({1'b0, d} >= STEP_W) ? (d - STEP_W[9:0]) : 10'd0;
  endfunction

  logic [9:0] eff_tgt, run_tgt, up_val;
  logic       tick_hit;

  assign eff_tgt  = min10(bus.duty_target, max_q);
  assign run_tgt  = min10(bus.duty_target, bus.maxcount_target);
  assign up_val   = sat_up(duty_q, eff_tgt);
  assign tick_hit = bus.period_end && (tick_q == bus.ramp_div);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      fl_q    <= 1'b0;
      duty_q  <= '0;
      max_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      fl_q    <= fl_d;
      duty_q  <= duty_d;
      max_q   <= max_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.fault && state_q != S_FAULT) begin
      state_d = S_FAULT;
    end else begin
      case (state_q)
        S_IDLE:   if (bus.start) state_d = S_RAMP;
        S_RAMP: begin
          if (bus.stop)
`ifdef DPWM_SEQ_RAMPDOWN_EN
            state_d = S_RAMPDN;
`else
            state_d = S_IDLE;
`endif
          else if (tick_hit && up_val == eff_tgt)
            state_d = S_RUN;
        end
        S_RUN:
          if (bus.stop)
`ifdef DPWM_SEQ_RAMPDOWN_EN
            state_d = S_RAMPDN;
`else
            state_d = S_IDLE;
`endif
`ifdef DPWM_SEQ_RAMPDOWN_EN
        S_RAMPDN: if (duty_q == 10'd0) state_d = S_IDLE;
`endif
        S_FAULT:  if (bus.fault_clr && !bus.fault) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs; priority fault > stop > start > period_end
  always_comb begin
    en_d   = en_q;
    fl_d   = fl_q;
    duty_d = duty_q;
    max_d  = max_q;
    tick_d = tick_q;
    if (bus.fault && state_q != S_FAULT) begin
      en_d   = 1'b0;
      duty_d = '0;
      fl_d   = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            max_d  = bus.maxcount_target;
            duty_d = DMIN_W;
            tick_d = '0;
            en_d   = 1'b1;
          end
        end
        S_RAMP, S_RUN: begin
          if (bus.stop) begin
            tick_d = '0;
`ifndef DPWM_SEQ_RAMPDOWN_EN
            en_d   = 1'b0;
            duty_d = '0;
`endif
          end else if (state_q == S_RUN) begin
            if (bus.period_end) begin
              duty_d = run_tgt;
              max_d  = bus.maxcount_target;
            end
          end else if (bus.period_end) begin
            tick_d = tick_hit ? 8'd0 : tick_q + 8'd1;
            if (tick_hit) duty_d = up_val;
          end
        end
`ifdef DPWM_SEQ_RAMPDOWN_EN
        S_RAMPDN: begin
          if (duty_q == 10'd0) begin
            en_d = 1'b0;
          end else if (bus.period_end) begin
            tick_d = tick_hit ? 8'd0 : tick_q + 8'd1;
            if (tick_hit) duty_d = sat_dn(duty_q);
          end
        end
`endif
        S_FAULT: begin
          if (bus.fault_clr && !bus.fault) fl_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifndef DPWM_SEQ_RAMPDOWN_EN
  logic [9:0] unused_dn;
  assign unused_dn = sat_dn(duty_q);
`endif

  assign bus.en            = en_q;
  assign bus.duty_cmd      = duty_q;
  assign bus.maxcount_cmd  = max_q;
  assign bus.state         = state_q;
  assign bus.fault_latched = fl_q;

endmodule

// File: tb/tb_dpwm_sequencer.sv
// Directed bench for dpwm_sequencer: soft start, saturation, retargeting, stop, fault and reset.
module tb_dpwm_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  dpwm_sequencer_if bus();

  dpwm_sequencer #(.STEP(1), .DMIN(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_pe();
    bus.period_end = 1'b1;
    step();
    bus.period_end = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, bus.state, 0);
    check({tag, "_en"}, bus.en, 0);
    check({tag, "_duty"}, bus.duty_cmd, 0);
    check({tag, "_max"}, bus.maxcount_cmd, 0);
    check({tag, "_fl"}, bus.fault_latched, 0);
  endtask

  task automatic do_start(input logic [9:0] dt, input logic [9:0] mt, input logic [7:0] rd);
    bus.duty_target     = dt;
    bus.maxcount_target = mt;
    bus.ramp_div        = rd;
    bus.start           = 1'b1;
    bus.period_end      = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.period_end = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 0; bus.stop = 0; bus.fault = 0; bus.fault_clr = 0; bus.period_end = 0;
    bus.duty_target = 0; bus.maxcount_target = 0; bus.ramp_div = 0;
    step();
    step();
    reset = 1'b0;
    check_zero("rst");

    // Soft start to 150; period_end coincident with start is not counted
    do_start(10'd150, 10'd357, 8'd0);
    check("start_en", bus.en, 1);
    check("start_state", bus.state, 1);
    check("start_duty", bus.duty_cmd, 0);
    check("start_max", bus.maxcount_cmd, 357);
    for (int i = 1; i <= 150; i++) begin
      pulse_pe();
      check("ramp_duty", bus.duty_cmd, i);
      if (i == 149) check("ramp_state149", bus.state, 1);
      step();
    end
    check("run_state", bus.state, 2);
    check("run_duty", bus.duty_cmd, 150);

    // Retarget mid-period takes effect only at period_end
    bus.duty_target = 10'd100;
    step();
    check("retarget_hold", bus.duty_cmd, 150);
    pulse_pe();
    check("retarget_new", bus.duty_cmd, 100);
    bus.duty_target = 10'd150;
    pulse_pe();
    check("retarget_back", bus.duty_cmd, 150);

    // Stop from RUN
    bus.ramp_div = 8'd1;
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
`ifdef DPWM_SEQ_RAMPDOWN_EN
    check("stop_state", bus.state, 3);
    for (int i = 1; i <= 300; i++) begin
      pulse_pe();
      if (i == 2) check("dn_duty2", bus.duty_cmd, 149);
    end
    check("dn_duty0", bus.duty_cmd, 0);
    check("dn_state", bus.state, 3);
    check("dn_en", bus.en, 1);
    step();
    check("dn_idle", bus.state, 0);
    check("dn_en_off", bus.en, 0);
`else
    check("stop_state", bus.state, 0);
    check("stop_en", bus.en, 0);
    check("stop_duty", bus.duty_cmd, 0);
`endif

    // Ramp saturates at maxcount when duty_target exceeds it
    do_start(10'd400, 10'd357, 8'd0);
    for (int i = 1; i <= 357; i++) begin
      pulse_pe();
      if (i == 356) check("sat_state356", bus.state, 1);
    end
    check("sat_duty", bus.duty_cmd, 357);
    check("sat_state", bus.state, 2);
    pulse_pe();
    check("sat_hold", bus.duty_cmd, 357);

    // ramp_div=2: three period_end per step
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_zero("rst2");
    do_start(10'd150, 10'd357, 8'd2);
    pulse_pe();
    pulse_pe();
    check("div2_hold", bus.duty_cmd, 0);
    pulse_pe();
    check("div2_step", bus.duty_cmd, 1);

    // Fault in RAMP at duty 40
    reset = 1'b1;
    step();
    reset = 1'b0;
    do_start(10'd150, 10'd357, 8'd0);
    for (int i = 0; i < 40; i++) pulse_pe();
    check("pre_fault_duty", bus.duty_cmd, 40);
    bus.fault = 1'b1;
    step();
    check("fault_state", bus.state, 4);
    check("fault_en", bus.en, 0);
    check("fault_duty", bus.duty_cmd, 0);
    check("fault_fl", bus.fault_latched, 1);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check("clr_blocked", bus.state, 4);
    bus.fault = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("fault_start_ign", bus.state, 4);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    check("clr_state", bus.state, 0);
    check("clr_fl", bus.fault_latched, 0);

    // Start outside IDLE ignored, then reset mid-ramp overrides fault and others
    do_start(10'd150, 10'd357, 8'd0);
    for (int i = 0; i < 10; i++) pulse_pe();
    bus.start = 1'b1;
    pulse_pe();
    bus.start = 1'b0;
    check("restart_ign", bus.duty_cmd, 11);
    reset = 1'b1;
    bus.fault = 1'b1;
    bus.stop = 1'b1;
    bus.period_end = 1'b1;
    step();
    reset = 1'b0;
    bus.fault = 1'b0;
    bus.stop = 1'b0;
    bus.period_end = 1'b0;
    check_zero("rst_ramp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
